keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan_pkg.sv | 31 +++
 rtl/keypad_scan_if.sv | 22 ++
 rtl/keypad_scan_debounce.sv | 45 ++++
 rtl/keypad_scan.sv | 110 +++++++++++
 4 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Build with KEYPAD_ACCUM_EN to add the hex-entry accumulator.
package keypad_scan_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kp_state_e;

  localparam logic [3:0] ROW0     = 4'b1110;
  localparam logic [3:0] ROW1     = 4'b1101;
  localparam logic [3:0] ROW2     = 4'b1011;
  localparam logic [3:0] ROW3     = 4'b0111;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Index of the single low bit in an active-low one-hot vector.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      ROW1:    low_idx = 2'd1;
      ROW2:    low_idx = 2'd2;
      ROW3:    low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    return $countones(~v) == 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Key delivery handshake between the scanner (master) and its consumer (slave).
// KEYPAD_ACCUM_EN adds the value bus carrying the hex-entry accumulator.
interface keypad_scan_if;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        ovf;
`ifdef KEYPAD_ACCUM_EN
  logic [31:0] value;
`endif

  modport master (input key_ack, output key_code, key_valid, ovf
`ifdef KEYPAD_ACCUM_EN
    , value
`endif
  );
  modport slave (output key_ack, input key_code, key_valid, ovf
`ifdef KEYPAD_ACCUM_EN
    , value
`endif
  );
endinterface

// File: rtl/keypad_scan_debounce.sv
// Column synchronizer plus stability counter: counts while the synchronized
// columns match pat_i and en_i is high, clears on any mismatch or when idle.
module kp_debounce
  import keypad_scan_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_i,
  input  logic       en_i,
  input  logic [3:0] pat_i,
  output logic [3:0] col_s_o,
  output logic       done_o,
  output logic       miss_o
);
  localparam int CW = cnt_w(DEBOUNCE_CYC);

  logic [3:0]    sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          match, term;

  assign match   = (sync2_q == pat_i);
  assign term    = (cnt_q == CW'(DEBOUNCE_CYC - 1));
  assign col_s_o = sync2_q;
  assign done_o  = en_i && match && term;
  assign miss_o  = en_i && !match;

  always_comb begin
    cnt_d = '0;
    if (en_i && match && !term) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= COL_IDLE;
      sync2_q <= COL_IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= col_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row rotation, single-key capture, press/release
// debounce and a one-deep key register with overflow flag (KEYPAD_ACCUM_EN: value).
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  output logic [3:0]   row,
  input  logic [3:0]   col,
  keypad_scan_if.master kp
);
  localparam int DW = cnt_w(SCAN_DIV);

  kp_state_e     state_q;
  logic [DW-1:0] div_q;
  logic [3:0]    row_q, pat_q, key_q, code_q;
  logic          valid_q, ovf_q;
  logic [3:0]    col_s, db_pat;
  logic          db_en, db_done, db_miss;
  logic          deliver, ack, accept;

  // RELEASE reuses the same counter, just waiting for an all-idle pattern.
  assign db_en  = (state_q == DEBOUNCE) || (state_q == RELEASE);
  assign db_pat = (state_q == RELEASE) ? COL_IDLE : pat_q;

  kp_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
    .clk     (clk),
    .rst     (rst),
    .col_i   (col),
    .en_i    (db_en),
    .pat_i   (db_pat),
    .col_s_o (col_s),
    .done_o  (db_done),
    .miss_o  (db_miss)
  );

  assign deliver = (state_q == DEBOUNCE) && db_done;
  assign ack     = kp.key_ack && valid_q;
  assign accept  = deliver && (!valid_q || kp.key_ack);

`ifdef KEYPAD_ACCUM_EN
  logic [31:0] value_q;
  always_ff @(posedge clk) begin
    if (!rst)        value_q <= '0;
    else if (accept) value_q <= (key_q == 4'hF) ? 32'h0 : {value_q[27:0], key_q};
  end
  assign kp.value = value_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SCAN;
      div_q   <= '0;
      row_q   <= ROW0;
      pat_q   <= COL_IDLE;
      key_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        SCAN: begin
          if (div_q == DW'(SCAN_DIV - 1)) begin
            div_q <= '0;
            if (one_low(col_s)) begin
              state_q <= DEBOUNCE;
              pat_q   <= col_s;
              key_q   <= {low_idx(row_q), low_idx(col_s)};
            end else begin
              row_q <= {row_q[2:0], row_q[3]};
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (db_done)      state_q <= PRESSED;
          else if (db_miss) state_q <= SCAN;
        end
        PRESSED: if (col_s == COL_IDLE) state_q <= RELEASE;
        RELEASE: begin
          if (db_done)      state_q <= SCAN;
          else if (db_miss) state_q <= PRESSED;
        end
      endcase

      if (ack) begin
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end
      // Delivery wins over a same-cycle ack so the new key stays valid.
      if (deliver) begin
        if (accept) begin
          code_q  <= key_q;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign row          = row_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.ovf       = ovf_q;
endmodule
